death_sequencer: RTL and testbench

//  Game-state controller downstream of the hazard sprites (apples, spikes).
//  ORs their is_collide outputs, runs the kid's death sequence (freeze, blink, game-over),

---
 rtl/death_sequencer_pkg.sv | 22 ++
 rtl/death_sequencer_sync2.sv | 23 ++
 rtl/death_sequencer.sv | 160 ++++++++++++++++
 tb/tb_death_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/death_sequencer_pkg.sv
// Shared state encoding and helpers for the kid's death sequencer.
package death_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_ALIVE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_DYING   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DEAD    = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESPAWN = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_ALIVE   = ST_ALIVE,
    S_DYING   = ST_DYING,
    S_DEAD    = ST_DEAD,
    S_RESPAWN = ST_RESPAWN
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/death_sequencer_sync2.sv
// Two-flop synchroniser, parameterised width, synchronous active-high reset to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         toggle_clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge toggle_clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/death_sequencer.sv
// Kid death sequence controller: hazard OR, blink, game-over, restart, level reset.
// Optional GODMODE_EN: synced god_mode masks hazards while ALIVE.
//
// state   | meaning
// ALIVE   | normal play; hazards (outside grace) kill, press restarts voluntarily
// DYING   | kid frozen and blinking for BLINK_TICKS ticks
// DEAD    | game-over overlay shown, waiting for restart press
// RESPAWN | level_rst held for RST_TICKS ticks
module death_sequencer
  import death_pkg::*;
#(
  parameter int N_HAZ       = 4,
  parameter int BLINK_TICKS = 6,
  parameter int RST_TICKS   = 2,
  parameter int GRACE_TICKS = 2,
  parameter int CNT_W       = 10,
  localparam int HIT_W      = (N_HAZ > 1) ? $clog2(N_HAZ) : 1
) (
  input  logic              toggle_clk,
  input  logic              rst,
  input  logic [N_HAZ-1:0]  hazard_hit,
  input  logic              restart_key,
  input  logic              god_mode,
  output logic              kid_freeze,
  output logic              kid_visible,
  output logic              show_game_over,
  output logic              level_rst,
  output logic [CNT_W-1:0]  death_count,
  output logic [HIT_W-1:0]  last_hit
);

  localparam int TMR_W   = $clog2(max2(BLINK_TICKS, RST_TICKS) + 1);
  localparam int GRACE_W = $clog2(GRACE_TICKS + 1);

  localparam logic [TMR_W-1:0]   BLINK_LOAD = TMR_W'(BLINK_TICKS - 1);
  localparam logic [TMR_W-1:0]   RST_LOAD   = TMR_W'(RST_TICKS - 1);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_TICKS);

  state_t             state;
  logic [TMR_W-1:0]   seq_tmr;
  logic [GRACE_W-1:0] grace_tmr;
  logic [N_HAZ-1:0]   hazard_s;
  logic               key_s2;
  logic               key_s3;
  logic               press;
  logic               grace;
  logic               hit;
  logic [HIT_W-1:0]   hit_idx;

  sync2 #(.W(N_HAZ)) u_sync_haz (
    .toggle_clk (toggle_clk),
    .rst        (rst),
    .d          (hazard_hit),
    .q          (hazard_s)
  );

  sync2 #(.W(1)) u_sync_key (
    .toggle_clk (toggle_clk),
    .rst        (rst),
    .d          (restart_key),
    .q          (key_s2)
  );

  assign press = key_s2 & ~key_s3;
  assign grace = |grace_tmr;

`ifdef GODMODE_EN
  logic god_s;

  sync2 #(.W(1)) u_sync_god (
    .toggle_clk (toggle_clk),
    .rst        (rst),
    .d          (god_mode),
    .q          (god_s)
  );

  assign hit = (|hazard_s) & ~grace & ~god_s;
`else
  logic god_unused;
  assign god_unused = god_mode;
  assign hit        = (|hazard_s) & ~grace;
`endif

  // Lowest set bit identifies the killing hazard.
  always_comb begin
    hit_idx = '0;
    for (int i = N_HAZ - 1; i >= 0; i--) begin
      if (hazard_s[i]) hit_idx = HIT_W'(i);
    end
  end

  always_ff @(posedge toggle_clk) begin
    if (rst) begin
      state          <= S_ALIVE;
      key_s3         <= 1'b0;
      seq_tmr        <= '0;
      grace_tmr      <= '0;
      kid_freeze     <= 1'b0;
      kid_visible    <= 1'b1;
      show_game_over <= 1'b0;
      level_rst      <= 1'b0;
      death_count    <= '0;
      last_hit       <= '0;
    end else begin
      key_s3 <= key_s2;
      case (state)
        S_ALIVE: begin
          if (grace) grace_tmr <= grace_tmr - 1'b1;
          if (hit) begin
            state       <= S_DYING;
            kid_freeze  <= 1'b1;
            kid_visible <= 1'b0;
            seq_tmr     <= BLINK_LOAD;
            last_hit    <= hit_idx;
            if (death_count != '1) death_count <= death_count + 1'b1;
          end else if (press) begin
            state          <= S_RESPAWN;
            level_rst      <= 1'b1;
            kid_freeze     <= 1'b1;
            kid_visible    <= 1'b1;
            show_game_over <= 1'b0;
            seq_tmr        <= RST_LOAD;
          end
        end
        S_DYING: begin
          if (seq_tmr == '0) begin
            state          <= S_DEAD;
            kid_visible    <= 1'b0;
            show_game_over <= 1'b1;
          end else begin
            seq_tmr     <= seq_tmr - 1'b1;
            kid_visible <= ~kid_visible;
          end
        end
        S_DEAD: begin
          kid_freeze <= 1'b1;
          if (press) begin
            state          <= S_RESPAWN;
            level_rst      <= 1'b1;
            kid_visible    <= 1'b1;
            show_game_over <= 1'b0;
            seq_tmr        <= RST_LOAD;
          end
        end
        S_RESPAWN: begin
          if (seq_tmr == '0) begin
            state      <= S_ALIVE;
            level_rst  <= 1'b0;
            kid_freeze <= 1'b0;
            grace_tmr  <= GRACE_LOAD;
          end else begin
            seq_tmr <= seq_tmr - 1'b1;
          end
        end
        default: state <= S_ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_death_sequencer.sv
// Directed self-checking bench for death_sequencer (define GODMODE_EN to match a god-mode build).
module tb_death_sequencer;

  logic       toggle_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hazard_hit = '0;
  logic       restart_key = 1'b0;
  logic       god_mode = 1'b0;
  logic       kid_freeze;
  logic       kid_visible;
  logic       show_game_over;
  logic       level_rst;
  logic [9:0] death_count;
  logic [1:0] last_hit;

  int errors = 0;
  int checks = 0;

  death_sequencer dut (
    .toggle_clk     (toggle_clk),
    .rst            (rst),
    .hazard_hit     (hazard_hit),
    .restart_key    (restart_key),
    .god_mode       (god_mode),
    .kid_freeze     (kid_freeze),
    .kid_visible    (kid_visible),
    .show_game_over (show_game_over),
    .level_rst      (level_rst),
    .death_count    (death_count),
    .last_hit       (last_hit)
  );

  always #5 toggle_clk = ~toggle_clk;

  task automatic tick();
    @(posedge toggle_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_game_over(input string tag);
    int n = 0;
    while (!show_game_over && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(show_game_over), 32'd1);
  endtask

  task automatic wait_freeze(input logic v, input string tag);
    int n = 0;
    while (kid_freeze !== v && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(kid_freeze), 32'(v));
  endtask

  task automatic press_key();
    restart_key = 1'b1;
    tick();
    tick();
    restart_key = 1'b0;
  endtask

  initial begin
    int guard;

    // 1: reset and idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_freeze", 32'(kid_freeze), 32'd0);
    check("rst_visible", 32'(kid_visible), 32'd1);
    check("rst_game_over", 32'(show_game_over), 32'd0);
    check("rst_level_rst", 32'(level_rst), 32'd0);
    check("rst_count", 32'(death_count), 32'd0);
    check("rst_last_hit", 32'(last_hit), 32'd0);

    // 2: hazard 2 held 3 ticks, death at edge 2, blink, DEAD at edge 8
    hazard_hit = 4'b0100;
    tick();
    tick();
    check("t2_e1_freeze", 32'(kid_freeze), 32'd0);
    tick();
    check("t2_e2_freeze", 32'(kid_freeze), 32'd1);
    check("t2_e2_count", 32'(death_count), 32'd1);
    check("t2_e2_last_hit", 32'(last_hit), 32'd2);
    check("t2_e2_visible", 32'(kid_visible), 32'd0);
    hazard_hit = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_blink", 32'(kid_visible), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_blink_go", 32'(show_game_over), 32'd0);
    end
    tick();
    check("t2_e8_game_over", 32'(show_game_over), 32'd1);
    check("t2_e8_visible", 32'(kid_visible), 32'd0);
    check("t2_e8_freeze", 32'(kid_freeze), 32'd1);

    // 3: restart from DEAD, level_rst 2 ticks, grace masks 2 ALIVE ticks
    press_key();
    tick();
    check("t3_rsp_level_rst", 32'(level_rst), 32'd1);
    check("t3_rsp_game_over", 32'(show_game_over), 32'd0);
    check("t3_rsp_visible", 32'(kid_visible), 32'd1);
    check("t3_rsp_freeze", 32'(kid_freeze), 32'd1);
    hazard_hit = 4'b0001;
    tick();
    check("t3_rsp2_level_rst", 32'(level_rst), 32'd1);
    tick();
    check("t3_alive_level_rst", 32'(level_rst), 32'd0);
    check("t3_alive_freeze", 32'(kid_freeze), 32'd0);
    tick();
    check("t3_grace1_freeze", 32'(kid_freeze), 32'd0);
    tick();
    check("t3_grace2_freeze", 32'(kid_freeze), 32'd0);
    tick();
    check("t3_post_grace_freeze", 32'(kid_freeze), 32'd1);
    check("t3_count", 32'(death_count), 32'd2);
    check("t3_last_hit", 32'(last_hit), 32'd0);
    hazard_hit = 4'b0000;

    // 4a: press during DYING is ignored
    press_key();
    tick();
    check("t4_dying_level_rst", 32'(level_rst), 32'd0);
    check("t4_dying_freeze", 32'(kid_freeze), 32'd1);
    tick();
    tick();
    tick();
    check("t4_dead_game_over", 32'(show_game_over), 32'd1);
    repeat (3) tick();
    check("t4_dead_hold_level_rst", 32'(level_rst), 32'd0);
    check("t4_dead_hold_go", 32'(show_game_over), 32'd1);

    // 4b: hit and press on the same edge in ALIVE -> hit wins
    press_key();
    tick();
    check("t4_rsp_level_rst", 32'(level_rst), 32'd1);
    repeat (6) tick();
    check("t4_alive_freeze", 32'(kid_freeze), 32'd0);
    hazard_hit = 4'b1000;
    press_key();
    check("t4_pre_both_freeze", 32'(kid_freeze), 32'd0);
    tick();
    check("t4_both_freeze", 32'(kid_freeze), 32'd1);
    check("t4_both_level_rst", 32'(level_rst), 32'd0);
    check("t4_both_count", 32'(death_count), 32'd3);
    check("t4_both_last_hit", 32'(last_hit), 32'd3);
    hazard_hit = 4'b0000;

    // 5: saturate death_count, then reset while DEAD
    hazard_hit = 4'b0010;
    guard = 0;
    while (death_count !== 10'd1023 && guard < 40000) begin
      if (show_game_over) press_key();
      tick();
      guard++;
    end
    check("t5_reach_max", 32'(death_count), 32'd1023);
    wait_game_over("t5_wait_dead");
    press_key();
    wait_freeze(1'b0, "t5_wait_alive");
    wait_freeze(1'b1, "t5_wait_die");
    check("t5_sat_count", 32'(death_count), 32'd1023);
    check("t5_sat_last_hit", 32'(last_hit), 32'd1);
    wait_game_over("t5_wait_dead2");
    hazard_hit = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_freeze", 32'(kid_freeze), 32'd0);
    check("t5_rst_visible", 32'(kid_visible), 32'd1);
    check("t5_rst_game_over", 32'(show_game_over), 32'd0);
    check("t5_rst_count", 32'(death_count), 32'd0);

    // 6: god mode with all hazards asserted
    repeat (4) tick();
    god_mode = 1'b1;
    hazard_hit = 4'hF;
    repeat (10) tick();
`ifdef GODMODE_EN
    check("t6_god_freeze", 32'(kid_freeze), 32'd0);
    check("t6_god_count", 32'(death_count), 32'd0);
`else
    check("t6_nogod_freeze", 32'(kid_freeze), 32'd1);
    check("t6_nogod_count", 32'(death_count), 32'd1);
    check("t6_nogod_last_hit", 32'(last_hit), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
